counter_display_driver: RTL and testbench



---
 rtl/counter_display_driver.sv | 168 ++++++++++++++++
 tb/tb_counter_display_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/counter_display_driver.sv
// Binary-to-BCD (double-dabble) converter driving a multiplexed common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module counter_display_driver #(
    parameter int N        = 10,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [$clog2(N)-1:0]   count,
    output logic [6:0]             seg,
    output logic [DIGITS-1:0]      an,
    output logic                   disp_valid
);
    localparam int W     = $clog2(N);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + W;
    localparam int CNT_W = $clog2(W + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (N < 2) begin : g_chk_n
        $error("counter_display_driver: N must be >= 2");
    end
    if ((10 ** DIGITS) < N) begin : g_chk_digits
        $error("counter_display_driver: DIGITS too small to represent N-1");
    end
    if (SCAN_DIV < 2) begin : g_chk_scan
        $error("counter_display_driver: SCAN_DIV must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             state_q, next_state;
    logic               load, latch;
    logic [W-1:0]       count_p0;
    logic [W-1:0]       last_q;
    logic               pending_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [SR_W-1:0]    sr_q;
    logic [BCD_W-1:0]   disp_bcd_q;
    logic [PRE_W-1:0]   pre_q;
    logic [IDX_W-1:0]   idx_q;
    logic               blank;
    logic [3:0]         nib;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[W + 4*d +: 4] >= 4'd5)
                t[W + 4*d +: 4] = t[W + 4*d +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Stage p0: input sample; free-running so it already holds count when reset releases.
    always_ff @(posedge clk) begin
        count_p0 <= count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        load       = 1'b0;
        latch      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q || (count_p0 != last_q)) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == CNT_W'(W - 1))
                    next_state = LATCH;
            end
            LATCH: begin
                latch      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 1'b1;
            last_q     <= '0;
            bit_cnt_q  <= '0;
            disp_bcd_q <= '0;
            disp_valid <= 1'b0;
        end else begin
            if (load) begin
                pending_q <= 1'b0;
                last_q    <= count_p0;
                bit_cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (latch) begin
                disp_bcd_q <= sr_q[SR_W-1 -: BCD_W];
                disp_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load)
            sr_q <= {{BCD_W{1'b0}}, count_p0};
        else if (state_q == SHIFT)
            sr_q <= dabble_step(sr_q);
    end

    always_comb begin
        nib = disp_bcd_q[4*idx_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q != '0) && ((disp_bcd_q >> (4*idx_q)) == '0);
`else
        blank = 1'b0;
`endif
    end

    // Scan: registered anode/segment drive follows the digit index by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
            an    <= '1;
            seg   <= 7'h7F;
        end else begin
            if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            if (disp_valid) begin
                an  <= ~(DIGITS'(1) << idx_q);
                seg <= blank ? 7'h7F : seg_decode(nib);
            end else begin
                an  <= '1;
                seg <= 7'h7F;
            end
        end
    end
endmodule

// File: tb/tb_counter_display_driver.sv
// Scoreboard bench for counter_display_driver (N=60, DIGITS=2, SCAN_DIV=4).
module tb_counter_display_driver;
    localparam int N = 60;
    localparam int DIGITS = 2;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       disp_valid;

    counter_display_driver #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .count(count),
        .seg(seg), .an(an), .disp_valid(disp_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [1:0] an;
        logic [6:0] seg;
        logic       dv;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   tcyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   base;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(posedge clk) tcyc <= tcyc + 1;

    // Expected display at cycle rel (relative to reset release) for a stable value d1 d0.
    task automatic expect_digits(input int rel, input int d1, input int d0, input string name);
        exp_t e;
        int   idx;
        idx    = ((rel - 1) / SCAN_DIV) % DIGITS;
        e.tag  = base + rel;
        e.dv   = 1'b1;
        e.name = name;
        if (idx == 0) begin
            e.an  = 2'b10;
            e.seg = seg_tbl[d0];
        end else begin
            e.an  = 2'b01;
            e.seg = seg_tbl[d1];
`ifdef LEADING_ZERO_BLANK_EN
            if (d1 == 0) e.seg = 7'h7F;
`endif
        end
        sb_q.push_back(e);
    endtask

    task automatic expect_dark(input int rel, input logic dv, input string name);
        exp_t e;
        e.tag  = base + rel;
        e.an   = 2'b11;
        e.seg  = 7'h7F;
        e.dv   = dv;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic goto_rel(input int rel);
        while (tcyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].tag < tcyc) begin
            checks++;
            errors++;
            $display("FAIL %s: not observed at cycle %0d", sb_q[0].name, sb_q[0].tag);
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].tag == tcyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || disp_valid !== e.dv) begin
                errors++;
                $display("FAIL %s: got an=%b seg=%b disp_valid=%b, expected an=%b seg=%b disp_valid=%b",
                         e.name, an, seg, disp_valid, e.an, e.seg, e.dv);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        count   = 6'd0;
        base    = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base    = tcyc;

        expect_dark(0, 1'b0, "reset_state");
        expect_dark(7, 1'b0, "before_first_latch");
        expect_dark(8, 1'b1, "valid_before_drive");
        expect_digits(9, 0, 0, "first_zero");

        goto_rel(12);
        count = 6'd37;
        expect_digits(21, 0, 0, "old_value_held");
        expect_digits(22, 3, 7, "37_tens_first");
        expect_digits(24, 3, 7, "37_tens_hold");
        expect_digits(25, 3, 7, "37_units");
        expect_digits(28, 3, 7, "37_units_hold");
        expect_digits(29, 3, 7, "37_tens_again");

        goto_rel(32);
        count = 6'd12;
        expect_digits(41, 3, 7, "no_garbage");
        expect_digits(42, 1, 2, "12_units");
        expect_digits(45, 1, 2, "12_tens");
        expect_digits(50, 1, 3, "13_units");
        expect_digits(53, 1, 3, "13_tens");
        goto_rel(35);
        count = 6'd13;

        goto_rel(56);
        count = 6'd59;
        expect_digits(66, 5, 9, "59_units");
        expect_digits(69, 5, 9, "59_tens");
        expect_digits(77, 5, 9, "59_held");
        expect_digits(78, 0, 0, "wrap_tens");
        expect_digits(81, 0, 0, "wrap_units");
        goto_rel(68);
        count = 6'd0;

        goto_rel(84);
        count = 6'd45;
        goto_rel(89);
        expect_dark(89, 1'b0, "async_reset_mid_shift");
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base    = tcyc;
        expect_dark(0, 1'b0, "reset_released");
        expect_dark(7, 1'b0, "restart_not_valid");
        expect_dark(8, 1'b1, "restart_valid");
        expect_digits(9, 4, 5, "45_units");
        expect_digits(13, 4, 5, "45_tens");

        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", sb_q.size());
            errors += sb_q.size();
            checks += sb_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
